bio_keys: RTL

Debounced pushbutton and switch input unit for the board I/O space. It synchronizes the active-low keys and the slide switches, debounces each key with a stable-time counter, and latches press/release events. The CPU reads all of this as one 32-bit word, clears events write-1-to-clear, and can enable a level interrupt. The unit sits beside the LED/hex output block on the same I/O bus select style (`en`/`wr`/`din`/`dout`).

---
 rtl/bio_pkg.sv | 12 +
 rtl/key_debounce.sv | 48 ++++
 rtl/bio_keys.sv | 85 ++++++++
 3 files changed

// File: rtl/bio_pkg.sv
// Bit positions and sizes shared by the bio_keys input unit.
package bio_pkg;
  localparam int NUM_KEYS    = 3;
  localparam int NUM_SW      = 18;
  localparam int KEY_LVL_LSB = 0;
  localparam int KEY_PRS_LSB = 4;
  localparam int KEY_REL_LSB = 8;
  localparam int IRQ_EN_BIT  = 12;
  localparam int SW_LSB      = 14;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-time counter and debounced level.
// rise/fall pulse on the same edge at which the debounced level changes.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          key_sync;
  logic          settle;

  // Synchronizer idles at released (high) so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= 2'b11;
    else     sync_reg <= {sync_reg[0], key_n};
  end

  assign key_sync = ~sync_reg[1];
  assign settle   = (key_sync != stable_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (key_sync == stable_reg) begin
      cnt_reg <= '0;
    end else if (settle) begin
      stable_reg <= key_sync;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign level = stable_reg;
  assign rise  = settle & key_sync;
  assign fall  = settle & ~key_sync;
endmodule

// File: rtl/bio_keys.sv
// Debounced key / switch input unit with W1C event flags and a level interrupt.
// Optional feature macro: BIO_KEYS_RELEASE_EN (latch release events).
module bio_keys
  import bio_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_SW-1:0]   sw,
  output logic                irq
);
  key_vec_t          level, rise, fall;
  key_vec_t          press_reg, press_next, rel_flags;
  logic              irq_en_reg;
  logic              wr_en;
  logic [NUM_SW-1:0] sw_meta_reg, sw_sync_reg;
  logic              unused_bits;

  assign wr_en = en & wr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n[gi]),
        .level (level[gi]),
        .rise  (rise[gi]),
        .fall  (fall[gi])
      );
    end
  endgenerate

  // A set arriving on the clearing edge wins.
  assign press_next = (press_reg & ~(wr_en ? din[KEY_PRS_LSB +: NUM_KEYS] : '0)) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_reg   <= '0;
      irq_en_reg  <= 1'b0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      press_reg   <= press_next;
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
      if (wr_en) irq_en_reg <= din[IRQ_EN_BIT];
    end
  end

`ifdef BIO_KEYS_RELEASE_EN
  key_vec_t rel_reg, rel_next;

  assign rel_next = (rel_reg & ~(wr_en ? din[KEY_REL_LSB +: NUM_KEYS] : '0)) | fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rel_reg <= '0;
    else     rel_reg <= rel_next;
  end

  assign rel_flags   = rel_reg;
  assign unused_bits = ^{din[31:13], din[11], din[7], din[3:0]};
`else
  assign rel_flags   = '0;
  assign unused_bits = ^{din[31:13], din[11:7], din[3:0], fall};
`endif

  assign irq = irq_en_reg & (|press_reg | |rel_flags);

  always_comb begin
    dout = '0;
    dout[KEY_LVL_LSB +: NUM_KEYS] = level;
    dout[KEY_PRS_LSB +: NUM_KEYS] = press_reg;
    dout[KEY_REL_LSB +: NUM_KEYS] = rel_flags;
    dout[IRQ_EN_BIT]              = irq_en_reg;
    dout[SW_LSB +: NUM_SW]        = sw_sync_reg;
  end
endmodule
